// File: rtl/sr_pkg.sv
// Shared types and constants for the SR flag sequencer: FSM states,
// command op encodings, round-robin pointer values and default sizing.
package sr_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SETTLE = 2'd2
    } sr_state_t;

    localparam logic SR_OP_SET = 1'b1;
    localparam logic SR_OP_CLR = 1'b0;

    localparam logic RR_A = 1'b0;
    localparam logic RR_B = 1'b1;

    localparam int SR_N_FLAGS_DEF    = 8;
    localparam int SR_PULSE_CYC_DEF  = 2;
    localparam int SR_SETTLE_CYC_DEF = 1;

endpackage

// File: rtl/sr_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, and when both
// request, the one selected by rr_ptr wins.
module sr_rr_arb2
    import sr_pkg::*;
(
    input  logic a_valid,
    input  logic b_valid,
    input  logic rr_ptr,
    output logic gnt_a,
    output logic gnt_b
);

    // Grant selection from valids and the round-robin pointer
    always_comb begin
        gnt_a = a_valid && (!b_valid || (rr_ptr == RR_A));
        gnt_b = b_valid && (!a_valid || (rr_ptr == RR_B));
    end

endmodule

// File: rtl/sr_flag_sequencer.sv
// Sole driver of a bank of gated SR-latch flag cells: arbitrates set/clear
// commands from two requesters into timed single-hot S/R pulses with a shadow copy.
module sr_flag_sequencer
    import sr_pkg::*;
#(
    parameter int N_FLAGS    = SR_N_FLAGS_DEF,
    parameter int PULSE_CYC  = SR_PULSE_CYC_DEF,
    parameter int SETTLE_CYC = SR_SETTLE_CYC_DEF,
    // One extra code point so out-of-range indices can be expressed and flagged
    localparam int IDX_W     = $clog2(N_FLAGS + 1)
)
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               a_valid,
    input  logic               a_op,
    input  logic [IDX_W-1:0]   a_idx,
    output logic               a_ready,
    input  logic               b_valid,
    input  logic               b_op,
    input  logic [IDX_W-1:0]   b_idx,
    output logic               b_ready,
    output logic [N_FLAGS-1:0] sr_s,
    output logic [N_FLAGS-1:0] sr_r,
    output logic               sr_en,
    output logic [N_FLAGS-1:0] flags,
    output logic               busy,
    output logic               idx_err
);

    localparam int               CNT_W     = $clog2(PULSE_CYC + SETTLE_CYC + 1);
    localparam logic [IDX_W-1:0] IDX_LIMIT = IDX_W'(N_FLAGS);

    function automatic logic [N_FLAGS-1:0] idx_to_mask(input logic [IDX_W-1:0] idx);
        logic [N_FLAGS-1:0] m;
        m = '0;
        for (int i = 0; i < N_FLAGS; i++) begin
            m[i] = (idx == IDX_W'(i));
        end
        return m;
    endfunction

    sr_state_t          state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic               op_r, op_s;
    logic [N_FLAGS-1:0] sel_r, sel_s;
    logic               rr_ptr_r, rr_ptr_s;
    logic [N_FLAGS-1:0] set_pins_r, set_pins_s;
    logic [N_FLAGS-1:0] clr_pins_r, clr_pins_s;
    logic               en_r, en_s;
    logic [N_FLAGS-1:0] flags_r, flags_s;
    logic               busy_r, busy_s;
    logic               idx_err_r, idx_err_s;

    logic               gnt_a_s, gnt_b_s;
    logic               acc_s;
    logic               acc_op_s;
    logic [IDX_W-1:0]   acc_idx_s;
    logic [N_FLAGS-1:0] acc_mask_s;

    sr_rr_arb2 u_arb (
        .a_valid (a_valid),
        .b_valid (b_valid),
        .rr_ptr  (rr_ptr_r),
        .gnt_a   (gnt_a_s),
        .gnt_b   (gnt_b_s)
    );

    // Readies and the accepted command, only meaningful while idle
    always_comb begin
        a_ready    = gnt_a_s && (state_r == IDLE);
        b_ready    = gnt_b_s && (state_r == IDLE);
        acc_s      = a_ready || b_ready;
        acc_op_s   = a_ready ? a_op  : b_op;
        acc_idx_s  = a_ready ? a_idx : b_idx;
        acc_mask_s = idx_to_mask(acc_idx_s);
    end

    // Next-state, counter, pin, shadow and pointer logic
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        op_s       = op_r;
        sel_s      = sel_r;
        rr_ptr_s   = rr_ptr_r;
        set_pins_s = '0;
        clr_pins_s = '0;
        en_s       = 1'b0;
        flags_s    = flags_r;
        idx_err_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (acc_s) begin
                    op_s  = acc_op_s;
                    sel_s = acc_mask_s;
                    if (a_valid && b_valid) begin
                        rr_ptr_s = a_ready ? RR_B : RR_A;
                    end else begin
                        rr_ptr_s = rr_ptr_r;
                    end
                    if (acc_idx_s >= IDX_LIMIT) begin
                        idx_err_s = 1'b1;
                    end else begin
                        state_s    = DRIVE;
                        cnt_s      = CNT_W'(PULSE_CYC - 1);
                        en_s       = 1'b1;
                        set_pins_s = (acc_op_s == SR_OP_SET) ? acc_mask_s : '0;
                        clr_pins_s = (acc_op_s == SR_OP_SET) ? '0 : acc_mask_s;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            DRIVE: begin
                if (cnt_r == '0) begin
                    // Pins drop here so the shadow update lines up with the first settle cycle
                    state_s = SETTLE;
                    cnt_s   = CNT_W'(SETTLE_CYC - 1);
                    flags_s = (op_r == SR_OP_SET) ? (flags_r | sel_r) : (flags_r & ~sel_r);
                end else begin
                    cnt_s      = cnt_r - CNT_W'(1);
                    en_s       = 1'b1;
                    set_pins_s = (op_r == SR_OP_SET) ? sel_r : '0;
                    clr_pins_s = (op_r == SR_OP_SET) ? '0 : sel_r;
                end
            end
            SETTLE: begin
                if (cnt_r == '0) begin
                    state_s = IDLE;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
        busy_s = (state_s != IDLE);
    end

    // State and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            cnt_r      <= '0;
            op_r       <= 1'b0;
            sel_r      <= '0;
            rr_ptr_r   <= RR_A;
            set_pins_r <= '0;
            clr_pins_r <= '0;
            en_r       <= 1'b0;
            flags_r    <= '0;
            busy_r     <= 1'b0;
            idx_err_r  <= 1'b0;
        end else begin
            state_r    <= state_s;
            cnt_r      <= cnt_s;
            op_r       <= op_s;
            sel_r      <= sel_s;
            rr_ptr_r   <= rr_ptr_s;
            set_pins_r <= set_pins_s;
            clr_pins_r <= clr_pins_s;
            en_r       <= en_s;
            flags_r    <= flags_s;
            busy_r     <= busy_s;
            idx_err_r  <= idx_err_s;
        end
    end

    assign sr_s    = set_pins_r;
    assign sr_r    = clr_pins_r;
    assign sr_en   = en_r;
    assign flags   = flags_r;
    assign busy    = busy_r;
    assign idx_err = idx_err_r;

endmodule
